jk_sync_counter: RTL and testbench

Parametrised synchronous up/down counter built from an array of JK bit cells, the multi-bit, mode-capable successor to the dual JK flip-flop part in the 7400 library. It serves as the program counter, ring/step counter and any loadable counter in the SAP datapath. It supports binary or truncated modulus, parallel load, synchronous clear and count-enable cascading through a ripple-carry output.

---
 rtl/sn74_pkg.sv | 17 +
 rtl/jk_bit.sv | 36 +++
 rtl/jk_sync_counter.sv | 87 ++++++++
 tb/tb_jk_sync_counter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sn74_pkg.sv
// Shared definitions for the 74-series style counter parts: JK cell function
// encodings and the modulus range check used at elaboration.
package sn74_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_fn_e;

  // True when 2 <= modulus <= 2**width.
  function automatic logic modulus_ok(input int unsigned width, input int unsigned modulus);
    return (modulus >= 32'd2) && (64'(modulus) <= (64'd1 << width));
  endfunction

endpackage

// File: rtl/jk_bit.sv
// Single JK flip-flop with asynchronous active-low clear; Q_bar is the
// complement of the stored bit.
module jk_bit
  import sn74_pkg::*;
(
  input  logic CLK,
  input  logic CLR_bar,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Q_bar
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (jk_fn_e'({J, K}))
      JK_HOLD:   q_d = q_q;
      JK_RESET:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) q_q <= 1'b0;
    else          q_q <= q_d;
  end

  assign Q     = q_q;
  assign Q_bar = ~q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Loadable synchronous up/down modulus counter built from JK bit cells.
// Only J/K steering, the carry chain, terminal detect and RCO live here.
module jk_sync_counter
  import sn74_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 32'd1 << WIDTH
) (
  input  logic             CLK,
  input  logic             CLR_bar,
  input  logic             SCLR_bar,
  input  logic             LOAD_bar,
  input  logic [WIDTH-1:0] D,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             RCO
);

  localparam logic [WIDTH-1:0] MOD_M1 = WIDTH'(MODULUS - 32'd1);

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("jk_sync_counter: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] qb_w;
  logic [WIDTH-1:0] j_c;
  logic [WIDTH-1:0] k_c;
  logic [WIDTH-1:0] carry_c;
  logic [WIDTH-1:0] wrap_c;
  logic [WIDTH-1:0] toggle_c;
  logic [WIDTH-1:0] d_eff_c;
  logic             terminal_c;

  // Up/down carry chain: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic run;
    run     = 1'b1;
    carry_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      carry_c[i] = run;
      run        = run & (UP ? q_w[i] : ~q_w[i]);
    end
  end

  // At the terminal state the toggle mask jumps straight to the wrap value.
  always_comb begin
    terminal_c = UP ? (q_w == MOD_M1) : (q_w == '0);
    wrap_c     = UP ? '0 : MOD_M1;
    toggle_c   = terminal_c ? (q_w ^ wrap_c) : carry_c;
    d_eff_c    = (32'(D) < MODULUS) ? D : MOD_M1;
  end

  // Cell steering in priority order: sync clear, load, count, hold.
  always_comb begin
    j_c = '0;
    k_c = '0;
    if (!SCLR_bar) begin
      k_c = '1;
    end else if (!LOAD_bar) begin
      j_c = d_eff_c;
      k_c = ~d_eff_c;
    end else if (ENP && ENT) begin
      j_c = toggle_c;
      k_c = toggle_c;
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    jk_bit u_bit (
      .CLK    (CLK),
      .CLR_bar(CLR_bar),
      .J      (j_c[i]),
      .K      (k_c[i]),
      .Q      (q_w[i]),
      .Q_bar  (qb_w[i])
    );
  end

  assign Q     = q_w;
  assign Q_bar = qb_w;
  assign RCO   = ENT & terminal_c;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed bench for jk_sync_counter: hex and decade instances plus a
// two-stage cascade, all sharing one clock.
module tb_jk_sync_counter;

  logic clk;
  int   tests_run;
  int   tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hex counter (WIDTH=4, MODULUS=16)
  logic       h_clr, h_sclr, h_load, h_enp, h_ent, h_up, h_rco;
  logic [3:0] h_d, h_q, h_qb;
  // Decade counter (WIDTH=4, MODULUS=10)
  logic       d_clr, d_sclr, d_load, d_enp, d_ent, d_up, d_rco;
  logic [3:0] d_d, d_q, d_qb;
  // Cascade of two hex counters
  logic       c_clr, c_sclr, c_load, c_enp, c_ent, c_up, c_rco0, c_rco1;
  logic [3:0] c_d, c_q0, c_q1, c_qb0, c_qb1;

  jk_sync_counter #(.WIDTH(4), .MODULUS(16)) u_hex (
    .CLK(clk), .CLR_bar(h_clr), .SCLR_bar(h_sclr), .LOAD_bar(h_load), .D(h_d),
    .ENP(h_enp), .ENT(h_ent), .UP(h_up), .Q(h_q), .Q_bar(h_qb), .RCO(h_rco)
  );

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) u_dec (
    .CLK(clk), .CLR_bar(d_clr), .SCLR_bar(d_sclr), .LOAD_bar(d_load), .D(d_d),
    .ENP(d_enp), .ENT(d_ent), .UP(d_up), .Q(d_q), .Q_bar(d_qb), .RCO(d_rco)
  );

  jk_sync_counter #(.WIDTH(4), .MODULUS(16)) u_c0 (
    .CLK(clk), .CLR_bar(c_clr), .SCLR_bar(c_sclr), .LOAD_bar(c_load), .D(c_d),
    .ENP(c_enp), .ENT(c_ent), .UP(c_up), .Q(c_q0), .Q_bar(c_qb0), .RCO(c_rco0)
  );

  jk_sync_counter #(.WIDTH(4), .MODULUS(16)) u_c1 (
    .CLK(clk), .CLR_bar(c_clr), .SCLR_bar(c_sclr), .LOAD_bar(c_load), .D(c_d),
    .ENP(c_enp), .ENT(c_rco0), .UP(c_up), .Q(c_q1), .Q_bar(c_qb1), .RCO(c_rco1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    h_ent = 1'b1;
    h_up  = 1'b0;
    #1;
    tests_run++;
    if (h_q !== 4'h0 || h_qb !== 4'hF) begin
      tests_failed++;
      $display("FAIL reset_q: got Q=%h Q_bar=%h, expected Q=0 Q_bar=f", h_q, h_qb);
    end
    tests_run++;
    if (h_rco !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_rco_down: got %b, expected 1", h_rco);
    end
    h_up = 1'b1;
    #1;
    tests_run++;
    if (h_rco !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rco_up: got %b, expected 0", h_rco);
    end
    h_ent = 1'b0;
    // Leave reset, load 6, count once to 7
    @(negedge clk);
    h_clr  = 1'b1;
    h_load = 1'b0;
    h_d    = 4'h6;
    tick();
    h_load = 1'b1;
    h_enp  = 1'b1;
    h_ent  = 1'b1;
    h_up   = 1'b1;
    tick();
    tests_run++;
    if (h_q !== 4'h7) begin
      tests_failed++;
      $display("FAIL pre_clear_count: got %h, expected 7", h_q);
    end
    // Async clear between edges while counting
    #1;
    h_clr = 1'b0;
    #1;
    tests_run++;
    if (h_q !== 4'h0 || h_qb !== 4'hF) begin
      tests_failed++;
      $display("FAIL async_clear: got Q=%h Q_bar=%h, expected Q=0 Q_bar=f", h_q, h_qb);
    end
    #1;
    h_clr = 1'b1;
    tick();
    tests_run++;
    if (h_q !== 4'h1 || h_qb !== 4'hE) begin
      tests_failed++;
      $display("FAIL first_edge_after_clear: got Q=%h Q_bar=%h, expected Q=1 Q_bar=e", h_q, h_qb);
    end
    // Binary down wrap from 0
    h_sclr = 1'b0;
    tick();
    h_sclr = 1'b1;
    h_up   = 1'b0;
    tick();
    tests_run++;
    if (h_q !== 4'hF) begin
      tests_failed++;
      $display("FAIL hex_down_wrap: got %h, expected f", h_q);
    end
    h_enp = 1'b0;
    h_ent = 1'b0;
  endtask

  task automatic test_decade_up();
    logic [3:0] exp_q;
    d_clr  = 1'b1;
    d_sclr = 1'b0;
    tick();
    d_sclr = 1'b1;
    d_enp  = 1'b1;
    d_ent  = 1'b1;
    d_up   = 1'b1;
    tests_run++;
    if (d_q !== 4'h0) begin
      tests_failed++;
      $display("FAIL dec_start: got %h, expected 0", d_q);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_q = (k == 9) ? 4'd0 : 4'(k + 1);
      tests_run++;
      if (d_q !== exp_q || d_qb !== ~exp_q) begin
        tests_failed++;
        $display("FAIL dec_up_step%0d: got Q=%h Q_bar=%h, expected Q=%h", k, d_q, d_qb, exp_q);
      end
      tests_run++;
      if (d_rco !== (exp_q == 4'd9)) begin
        tests_failed++;
        $display("FAIL dec_up_rco%0d: got %b at Q=%h, expected %b", k, d_rco, d_q, exp_q == 4'd9);
      end
    end
  endtask

  task automatic test_down_clamp();
    d_up = 1'b0;
    #1;
    tests_run++;
    if (d_rco !== 1'b1) begin
      tests_failed++;
      $display("FAIL dec_down_rco_at0: got %b, expected 1", d_rco);
    end
    tick();
    tests_run++;
    if (d_q !== 4'd9) begin
      tests_failed++;
      $display("FAIL dec_down_wrap: got %h, expected 9", d_q);
    end
    d_enp  = 1'b0;
    d_load = 1'b0;
    d_d    = 4'hC;
    tick();
    tests_run++;
    if (d_q !== 4'd9) begin
      tests_failed++;
      $display("FAIL load_clamp: got %h, expected 9", d_q);
    end
    d_d = 4'd3;
    tick();
    tests_run++;
    if (d_q !== 4'd3) begin
      tests_failed++;
      $display("FAIL load_in_range: got %h, expected 3", d_q);
    end
    d_load = 1'b1;
  endtask

  task automatic test_priority();
    d_up   = 1'b1;
    d_enp  = 1'b1;
    d_ent  = 1'b1;
    d_sclr = 1'b0;
    d_load = 1'b0;
    d_d    = 4'd5;
    tick();
    tests_run++;
    if (d_q !== 4'd0) begin
      tests_failed++;
      $display("FAIL sclr_over_load: got %h, expected 0", d_q);
    end
    d_sclr = 1'b1;
    tick();
    tests_run++;
    if (d_q !== 4'd5) begin
      tests_failed++;
      $display("FAIL load_over_count: got %h, expected 5", d_q);
    end
    d_d = 4'd9;
    tick();
    d_load = 1'b1;
    d_enp  = 1'b0;
    #1;
    tests_run++;
    if (d_rco !== 1'b1) begin
      tests_failed++;
      $display("FAIL rco_without_enp: got %b, expected 1", d_rco);
    end
    tick();
    tests_run++;
    if (d_q !== 4'd9 || d_rco !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_enp0: got Q=%h RCO=%b, expected Q=9 RCO=1", d_q, d_rco);
    end
    d_enp = 1'b1;
    d_ent = 1'b0;
    tick();
    tests_run++;
    if (d_q !== 4'd9 || d_rco !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_ent0: got Q=%h RCO=%b, expected Q=9 RCO=0", d_q, d_rco);
    end
    d_ent = 1'b1;
    d_up  = 1'b0;
    #1;
    tests_run++;
    if (d_rco !== 1'b0) begin
      tests_failed++;
      $display("FAIL rco_follows_up: got %b, expected 0", d_rco);
    end
    tick();
    tests_run++;
    if (d_q !== 4'd8) begin
      tests_failed++;
      $display("FAIL dec_down_step: got %h, expected 8", d_q);
    end
    d_enp = 1'b0;
    d_ent = 1'b0;
  endtask

  task automatic test_cascade();
    c_clr = 1'b1;
    c_enp = 1'b1;
    c_up  = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      tick();
      tests_run++;
      if ({c_q1, c_q0} !== 8'(k)) begin
        tests_failed++;
        $display("FAIL cascade_step%0d: got %h, expected %h", k, {c_q1, c_q0}, 8'(k));
      end
    end
    tests_run++;
    if (c_rco1 !== 1'b1 || {c_qb1, c_qb0} !== 8'h00) begin
      tests_failed++;
      $display("FAIL cascade_terminal: got RCO1=%b Q_bar=%h, expected RCO1=1 Q_bar=00", c_rco1, {c_qb1, c_qb0});
    end
    tick();
    tests_run++;
    if ({c_q1, c_q0} !== 8'h00 || c_rco1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL cascade_wrap: got Q=%h RCO1=%b, expected Q=00 RCO1=0", {c_q1, c_q0}, c_rco1);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    h_clr = 1'b0; h_sclr = 1'b1; h_load = 1'b1; h_d = '0; h_enp = 1'b0; h_ent = 1'b0; h_up = 1'b1;
    d_clr = 1'b0; d_sclr = 1'b1; d_load = 1'b1; d_d = '0; d_enp = 1'b0; d_ent = 1'b0; d_up = 1'b1;
    c_clr = 1'b0; c_sclr = 1'b1; c_load = 1'b1; c_d = '0; c_enp = 1'b0; c_ent = 1'b1; c_up = 1'b1;
    #12;
    test_reset();
    test_decade_up();
    test_down_clamp();
    test_priority();
    test_cascade();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
